serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_full_adder_cell.sv | 21 ++
 rtl/serial_adder.sv | 148 ++++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Definitions shared by the bit-serial adder:
//   - DEFAULT_WIDTH : default operand/result width in bits
//   - state_t       : control FSM states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Combinational one-bit full adder. This is the bit-slice used by serial_adder.
// Ports:
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit   (x ^ y ^ ci)
//   co   : carry out (majority of x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one bit of a+b+cin is produced per clock, LSB first,
// through a single full_adder_cell. A result takes WIDTH SHIFT cycles.
//
// Parameters:
//   WIDTH : operand/result width, 2..32
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   start : begin an operation (sampled only in IDLE or DONE)
//   a, b  : operands, captured on an accepted start
//   cin   : carry in, captured on an accepted start
//   sub   : (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b, cin ignored
//   busy  : high while shifting
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result register, holds its value until the next accepted start
//   cout  : final carry out (in subtract mode, 1 = no borrow)
//
// Build option:
//   SERIAL_ADDER_SUB_EN : when defined, adds the sub input and subtract mode.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Wide enough to hold WIDTH itself, so the count never wraps mid-operation.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  logic             fa_s;
  logic             fa_co;

  // ---------------------------------------------------------------------------
  // Operand preparation. Subtraction is a + ~b + 1, so it reuses the adder
  // datapath unchanged; the final carry is then the "no borrow" flag.
  // ---------------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  full_adder_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // The counter still shows WIDTH-1 during the final SHIFT cycle.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here
        if (last_bit) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples the
    // values from before this edge regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b_load;
        carry <= carry_load;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at sum[0].
        sum   <= {fa_s, sum[WIDTH-1:1]};
        carry <= fa_co;
        // Only the value written on the last shift matters.
        cout  <= fa_co;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH = 8). Expected results come from
// a plain arithmetic reference model and go into a queue when an operation is
// issued; a monitor pops and compares on every done pulse. Directed timing,
// reset, and back-to-back scenarios run first, then randomized operations.
// Subtract-mode cases are included when SERIAL_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks;
  int n_errors;
  int done_cnt;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } result_t;

  result_t exp_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the specified rules.
  function automatic result_t model(input int unsigned av, input int unsigned bv,
                                    input bit c, input bit s);
    result_t r;
    int unsigned full;
    if (s) begin
      r.sum  = WIDTH'(av - bv);
      r.cout = (av >= bv);
    end else begin
      full   = av + bv + c;
      r.sum  = WIDTH'(full);
      r.cout = 1'((full >> WIDTH) & 1);
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
      end
    end
  end

  // Call at a negedge: present operands with start=1 and record the expectation.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input bit c, input bit s);
    a     = av;
    b     = bv;
    cin   = c;
    sub_i = s;
    start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    exp_q.push_back(model(av, bv, c, s));
`else
    exp_q.push_back(model(av, bv, c, 1'b0));
`endif
  endtask

  // Counts negedges until done is seen; drops start after the first one.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done === 1'b1) return;
    end
    check("done_timeout", 32'd1, 32'd0);
    lat = -1;
  endtask

  initial begin
    int lat;
    int d0;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b1;            // start asserted during reset must be ignored
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", 32'(busy), 32'd0);

    // Basic add and latency: start edge plus 8 shifts -> done after 9 edges.
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check("latency", 32'(lat), 32'd9);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_held_idle", 32'(sum), 32'h10);

    // Carry-out boundaries.
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done(lat);
    @(negedge clk);

    // start held with new operands during SHIFT must be ignored.
    d0 = done_cnt;
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h55; b = 8'h33; cin = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_while_start_held", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("one_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Reset on the 4th SHIFT cycle aborts the operation.
    d0 = done_cnt;
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back: start held in DONE is accepted with no idle cycle.
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    wait_done(lat);
    issue(8'h80, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_latency", 32'(lat), 32'd8);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(lat);
    @(negedge clk);
    issue(8'h07, 8'h05, 1'b1, 1'b1);
    wait_done(lat);
    @(negedge clk);
`endif

    // Randomized operations, sometimes back-to-back from DONE.
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      issue(ra, rb, 1'($urandom), 1'($urandom));
`else
      issue(ra, rb, 1'($urandom), 1'b0);
`endif
      wait_done(lat);
      if ($urandom_range(1, 0) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_serial_adder
